pipelined_control_unit: RTL and testbench

- Successor to the single-bit registered ALU-source decoder.
- Decodes the 6-bit one-hot instruction type into a full control word and carries it down the pipeline as EX, MEM and WB stage fields.
- Handles stall, flush, bubble insertion and illegal-type detection, and keeps a retire counter.
- Sits between the type decoder in ID and the datapath stage registers.

---
 rtl/pipelined_control_unit.sv | 111 +++++++++++
 tb/tb_pipelined_control_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pipelined_control_unit.sv
// Decodes the one-hot instruction type into a control word and carries it through
// EX (EX_DEPTH front registers), MEM and WB, with stall/flush handling and a retire counter.
module pipelined_control_unit #(
  parameter int EX_DEPTH = 1,
  parameter int COUNT_W  = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [5:0]         instruction_type,
  input  logic               in_valid,
  input  logic               stall,
  input  logic               flush,
  output logic               ex_valid,
  output logic               ex_alusrc,
  output logic [1:0]         ex_aluop,
  output logic [2:0]         ex_immsel,
  output logic               ex_illegal,
  output logic               mem_valid,
  output logic               mem_memwrite,
  output logic               mem_branch,
  output logic               mem_jump,
  output logic               wb_valid,
  output logic               wb_regwrite,
  output logic [COUNT_W-1:0] retire_count
);

  typedef struct packed {
    logic       valid;
    logic       illegal;
    logic       alusrc;
    logic [1:0] aluop;
    logic [2:0] immsel;
    logic       regwrite;
    logic       memwrite;
    logic       branch;
    logic       jump;
  } ctrl_t;

  ctrl_t dec;
  ctrl_t front [EX_DEPTH];
  ctrl_t ex_word;
  logic  mem_regwrite;

  // NOTE: every field gets a default first so no path through the case infers a latch.
  always_comb begin
    dec = '0;
    if (in_valid) begin
      dec.valid = 1'b1;
      case (instruction_type)
        6'b100000: begin dec.aluop = 2'b10; dec.immsel = 3'd0; dec.regwrite = 1'b1; end
        6'b010000: begin dec.alusrc = 1'b1; dec.aluop = 2'b11; dec.immsel = 3'd1;
                         dec.regwrite = 1'b1; end
        6'b001000: begin dec.alusrc = 1'b1; dec.immsel = 3'd2; dec.memwrite = 1'b1; end
        6'b000100: begin dec.aluop = 2'b01; dec.immsel = 3'd3; dec.branch = 1'b1; end
        6'b000010: begin dec.immsel = 3'd4; dec.regwrite = 1'b1; dec.jump = 1'b1; end
        6'b000001: begin dec.alusrc = 1'b1; dec.immsel = 3'd5; dec.regwrite = 1'b1; end
        default:   begin dec.valid = 1'b0; dec.illegal = 1'b1; end
      endcase
    end
  end

  // NOTE: stage registers use non-blocking assignments so each stage samples the
  // previous stage's old value on the same edge.
  // The front array is reset as a whole: a stale valid bit would retire a ghost instruction.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      for (int i = 0; i < EX_DEPTH; i++) front[i] <= '0;
    end else if (!stall) begin
      front[0] <= dec;
      for (int i = 1; i < EX_DEPTH; i++) front[i] <= front[i-1];
    end
  end

  assign ex_word = front[EX_DEPTH-1];

  // A stalled EX word stays put, so MEM takes a bubble; flush alone lets EX drain.
  always_ff @(posedge clock) begin
    if (reset || stall) begin
      mem_valid    <= 1'b0;
      mem_regwrite <= 1'b0;
      mem_memwrite <= 1'b0;
      mem_branch   <= 1'b0;
      mem_jump     <= 1'b0;
    end else begin
      mem_valid    <= ex_word.valid;
      mem_regwrite <= ex_word.regwrite;
      mem_memwrite <= ex_word.memwrite;
      mem_branch   <= ex_word.branch;
      mem_jump     <= ex_word.jump;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wb_valid     <= 1'b0;
      wb_regwrite  <= 1'b0;
      retire_count <= '0;
    end else begin
      wb_valid    <= mem_valid;
      wb_regwrite <= mem_regwrite;
      if (wb_valid) retire_count <= retire_count + COUNT_W'(1);
    end
  end

  assign ex_valid   = ex_word.valid;
  assign ex_alusrc  = ex_word.alusrc;
  assign ex_aluop   = ex_word.aluop;
  assign ex_immsel  = ex_word.immsel;
  assign ex_illegal = ex_word.illegal;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench: a vector table for the EX_DEPTH=1 instance plus hand sequences
// for an EX_DEPTH=3, COUNT_W=4 instance (latency, wrap, multi-stage stall/flush).
module tb_pipelined_control_unit;

  localparam logic [5:0] T_R = 6'b100000, T_I = 6'b010000, T_S = 6'b001000;
  localparam logic [5:0] T_B = 6'b000100, T_J = 6'b000010, T_U = 6'b000001;
  // {valid, illegal, alusrc, aluop, immsel}
  localparam logic [7:0] E_0 = 8'b0_0_0_00_000, E_ILL = 8'b0_1_0_00_000;
  localparam logic [7:0] E_R = 8'b1_0_0_10_000, E_I = 8'b1_0_1_11_001;
  localparam logic [7:0] E_S = 8'b1_0_1_00_010, E_B = 8'b1_0_0_01_011;
  localparam logic [7:0] E_J = 8'b1_0_0_00_100, E_U = 8'b1_0_1_00_101;
  // {valid, memwrite, branch, jump}
  localparam logic [3:0] M_0 = 4'b0000, M_A = 4'b1000, M_S = 4'b1100;
  localparam logic [3:0] M_B = 4'b1010, M_J = 4'b1001;
  // {valid, regwrite}
  localparam logic [1:0] W_0 = 2'b00, W_RW = 2'b11, W_NR = 2'b10;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [5:0]  ty;
    logic        st;
    logic        fl;
    logic [7:0]  ex;
    logic [3:0]  mem;
    logic [1:0]  wb;
    logic [15:0] rc;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset1 = 1'b1, in_valid1 = 1'b0, stall1 = 1'b0, flush1 = 1'b0;
  logic [5:0]  type1 = '0;
  logic        ex_valid1, ex_alusrc1, ex_illegal1, mem_valid1, mem_memwrite1;
  logic        mem_branch1, mem_jump1, wb_valid1, wb_regwrite1;
  logic [1:0]  ex_aluop1;
  logic [2:0]  ex_immsel1;
  logic [15:0] rc1;

  logic        reset3 = 1'b1, in_valid3 = 1'b0, stall3 = 1'b0, flush3 = 1'b0;
  logic [5:0]  type3 = '0;
  logic        ex_valid3, ex_alusrc3, ex_illegal3, mem_valid3, mem_memwrite3;
  logic        mem_branch3, mem_jump3, wb_valid3, wb_regwrite3;
  logic [1:0]  ex_aluop3;
  logic [2:0]  ex_immsel3;
  logic [3:0]  rc3;

  pipelined_control_unit dut1 (
    .clock(clock), .reset(reset1), .instruction_type(type1), .in_valid(in_valid1),
    .stall(stall1), .flush(flush1), .ex_valid(ex_valid1), .ex_alusrc(ex_alusrc1),
    .ex_aluop(ex_aluop1), .ex_immsel(ex_immsel1), .ex_illegal(ex_illegal1),
    .mem_valid(mem_valid1), .mem_memwrite(mem_memwrite1), .mem_branch(mem_branch1),
    .mem_jump(mem_jump1), .wb_valid(wb_valid1), .wb_regwrite(wb_regwrite1),
    .retire_count(rc1)
  );

  pipelined_control_unit #(.EX_DEPTH(3), .COUNT_W(4)) dut3 (
    .clock(clock), .reset(reset3), .instruction_type(type3), .in_valid(in_valid3),
    .stall(stall3), .flush(flush3), .ex_valid(ex_valid3), .ex_alusrc(ex_alusrc3),
    .ex_aluop(ex_aluop3), .ex_immsel(ex_immsel3), .ex_illegal(ex_illegal3),
    .mem_valid(mem_valid3), .mem_memwrite(mem_memwrite3), .mem_branch(mem_branch3),
    .mem_jump(mem_jump3), .wb_valid(wb_valid3), .wb_regwrite(wb_regwrite3),
    .retire_count(rc3)
  );

  logic [7:0] ex_word1, ex_word3;
  logic [3:0] mem_word1;
  logic [1:0] wb_word1;
  assign ex_word1  = {ex_valid1, ex_illegal1, ex_alusrc1, ex_aluop1, ex_immsel1};
  assign ex_word3  = {ex_valid3, ex_illegal3, ex_alusrc3, ex_aluop3, ex_immsel3};
  assign mem_word1 = {mem_valid1, mem_memwrite1, mem_branch1, mem_jump1};
  assign wb_word1  = {wb_valid1, wb_regwrite1};

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic add(input logic rst, input logic vld, input logic [5:0] ty, input logic st,
                     input logic fl, input logic [7:0] ex, input logic [3:0] mem,
                     input logic [1:0] wb, input logic [15:0] rc);
    vec_t v;
    v.rst = rst; v.vld = vld; v.ty = ty; v.st = st; v.fl = fl;
    v.ex = ex; v.mem = mem; v.wb = wb; v.rc = rc;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // rst vld type stall flush | ex mem wb retire_count (after the edge)
    add(1, 0, 6'b0, 0, 0, E_0, M_0, W_0, 0);      // reset
    add(0, 1, T_R,  0, 0, E_R, M_0, W_0, 0);      // R..U back to back
    add(0, 1, T_I,  0, 0, E_I, M_A, W_0, 0);
    add(0, 1, T_S,  0, 0, E_S, M_A, W_RW, 0);
    add(0, 1, T_B,  0, 0, E_B, M_S, W_RW, 1);
    add(0, 1, T_J,  0, 0, E_J, M_B, W_NR, 2);
    add(0, 1, T_U,  0, 0, E_U, M_J, W_NR, 3);
    add(0, 0, 6'b0, 0, 0, E_0, M_A, W_RW, 4);
    add(0, 0, 6'b0, 0, 0, E_0, M_0, W_RW, 5);
    add(0, 0, 6'b0, 0, 0, E_0, M_0, W_0, 6);
    add(0, 1, T_I,  0, 0, E_I, M_0, W_0, 6);      // stall with S in EX
    add(0, 1, T_S,  0, 0, E_S, M_A, W_0, 6);
    add(0, 1, T_R,  1, 0, E_S, M_0, W_RW, 6);
    add(0, 1, T_R,  1, 0, E_S, M_0, W_0, 7);
    add(0, 0, 6'b0, 0, 0, E_0, M_S, W_0, 7);
    add(0, 0, 6'b0, 0, 0, E_0, M_0, W_NR, 7);
    add(0, 0, 6'b0, 0, 0, E_0, M_0, W_0, 8);
    add(0, 1, T_B,  0, 0, E_B, M_0, W_0, 8);      // flush: B drains, J killed
    add(0, 1, T_J,  0, 1, E_0, M_B, W_0, 8);
    add(0, 0, 6'b0, 0, 0, E_0, M_0, W_NR, 8);
    add(0, 0, 6'b0, 0, 0, E_0, M_0, W_0, 9);
    add(0, 1, T_R,  0, 0, E_R, M_0, W_0, 9);      // flush+stall
    add(0, 1, T_I,  1, 1, E_0, M_0, W_0, 9);
    add(0, 0, 6'b0, 0, 0, E_0, M_0, W_0, 9);
    add(0, 1, 6'b000000, 0, 0, E_ILL, M_0, W_0, 9); // illegal types
    add(0, 1, 6'b110000, 0, 0, E_ILL, M_0, W_0, 9);
    add(0, 0, T_R,  0, 0, E_0, M_0, W_0, 9);      // in_valid=0 is a bubble
    add(0, 0, 6'b0, 0, 0, E_0, M_0, W_0, 9);
    add(0, 1, T_R,  0, 0, E_R, M_0, W_0, 9);      // reset with 3 in flight
    add(0, 1, T_I,  0, 0, E_I, M_A, W_0, 9);
    add(0, 1, T_S,  0, 0, E_S, M_A, W_RW, 9);
    add(1, 1, T_U,  1, 1, E_0, M_0, W_0, 0);
    add(0, 0, 6'b0, 0, 0, E_0, M_0, W_0, 0);
    add(0, 0, 6'b0, 0, 0, E_0, M_0, W_0, 0);

    foreach (vecs[i]) begin
      reset1 = vecs[i].rst; in_valid1 = vecs[i].vld; type1 = vecs[i].ty;
      stall1 = vecs[i].st;  flush1 = vecs[i].fl;
      step();
      check($sformatf("v%0d_ex", i),  32'(ex_word1),  32'(vecs[i].ex));
      check($sformatf("v%0d_mem", i), 32'(mem_word1), 32'(vecs[i].mem));
      check($sformatf("v%0d_wb", i),  32'(wb_word1),  32'(vecs[i].wb));
      check($sformatf("v%0d_rc", i),  32'(rc1),       32'(vecs[i].rc));
    end

    // EX_DEPTH=3, COUNT_W=4: 17 back-to-back R instructions
    reset3 = 1'b0;
    for (int e = 1; e <= 25; e++) begin
      in_valid3 = (e <= 17);
      type3 = T_R;
      step();
      check($sformatf("d3_ex_valid_e%0d", e), 32'(ex_valid3), 32'(e >= 3 && e <= 19));
      check($sformatf("d3_mem_valid_e%0d", e), 32'(mem_valid3), 32'(e >= 4 && e <= 20));
      if (e == 20) check("d3_rc_15", 32'(rc3), 32'd15);
      if (e == 21) check("d3_rc_wrap", 32'(rc3), 32'd0);
      if (e >= 22) check($sformatf("d3_rc_end_e%0d", e), 32'(rc3), 32'd1);
    end

    // Stall holds every front stage
    in_valid3 = 1'b1; type3 = T_S; step();
    type3 = T_R; stall3 = 1'b1; step(); step();
    stall3 = 1'b0; in_valid3 = 1'b0; step();
    check("d3_stall_ex_not_yet", 32'(ex_valid3), 32'd0);
    step();
    check("d3_stall_ex_s", 32'(ex_word3), 32'(E_S));

    // Flush clears every front stage
    in_valid3 = 1'b1; type3 = T_B; step();
    check("d3_s_in_mem", 32'(mem_memwrite3), 32'd1);
    in_valid3 = 1'b0; flush3 = 1'b1; step();
    flush3 = 1'b0; step();
    check("d3_flush_e33", 32'(ex_valid3), 32'd0);
    step();
    check("d3_flush_e34", 32'(ex_valid3), 32'd0);
    check("d3_flush_no_branch", 32'(mem_branch3), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
